// File: rtl/sdram_wb_arbiter.sv
// sdram_wb_arbiter: round-robin two-master Wishbone arbiter in front of an SDRAM controller
// Ports: clk, rst (async, active-low); m0_*/m1_* Wishbone masters (m0 = fetch, m1 = data);
// s_* Wishbone slave side; gnt one-hot current grant (bit0 = m0, bit1 = m1).
// A granted master keeps the bus while its CYC is high; a stalled strobe is aborted
// with a forced ERR after TIMEOUT cycles without termination.
module sdram_wb_arbiter #(
   parameter int TIMEOUT = 1024,
   parameter int AW      = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_CYC,
   input  logic          m0_STB,
   input  logic          m0_WE,
   input  logic [AW-1:0] m0_ADR,
   input  logic [31:0]   m0_DAT_O,
   input  logic [2:0]    m0_CTI_O,
   output logic [31:0]   m0_DAT_I,
   output logic          m0_ACK,
   output logic          m0_ERR,
   output logic          m0_RTY,
   input  logic          m1_CYC,
   input  logic          m1_STB,
   input  logic          m1_WE,
   input  logic [AW-1:0] m1_ADR,
   input  logic [31:0]   m1_DAT_O,
   input  logic [2:0]    m1_CTI_O,
   output logic [31:0]   m1_DAT_I,
   output logic          m1_ACK,
   output logic          m1_ERR,
   output logic          m1_RTY,
   output logic          s_CYC,
   output logic          s_STB,
   output logic          s_WE,
   output logic [AW-1:0] s_ADR,
   output logic [31:0]   s_DAT_O,
   output logic [2:0]    s_CTI_O,
   input  logic [31:0]   s_DAT_I,
   input  logic          s_ACK,
   input  logic          s_ERR,
   input  logic          s_RTY,
   output logic [1:0]    gnt
);
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;
   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic [WW-1:0] wd_q, wd_d;
   logic          g0, g1, r0, r1, term, expire;
   always_comb begin
      g0       = state_q == GNT0;
      g1       = state_q == GNT1;
      r0       = m0_CYC & m0_STB;
      r1       = m1_CYC & m1_STB;
      gnt      = {g1, g0};
      s_CYC    = g0 ? m0_CYC   : g1 ? m1_CYC   : 1'b0;
      s_STB    = g0 ? m0_STB   : g1 ? m1_STB   : 1'b0;
      s_WE     = g0 ? m0_WE    : g1 ? m1_WE    : 1'b0;
      s_ADR    = g0 ? m0_ADR   : g1 ? m1_ADR   : '0;
      s_DAT_O  = g0 ? m0_DAT_O : g1 ? m1_DAT_O : '0;
      s_CTI_O  = g0 ? m0_CTI_O : g1 ? m1_CTI_O : 3'b000;
      term     = s_ACK | s_ERR | s_RTY;
      // a real slave termination in the last cycle wins over the forced abort
      expire   = (g0 | g1) & s_CYC & s_STB & ~term & (wd_q == WW'(TIMEOUT - 1));
      m0_ACK   = g0 & s_ACK;
      m0_ERR   = g0 & (s_ERR | expire);
      m0_RTY   = g0 & s_RTY;
      m0_DAT_I = g0 ? s_DAT_I : '0;
      m1_ACK   = g1 & s_ACK;
      m1_ERR   = g1 & (s_ERR | expire);
      m1_RTY   = g1 & s_RTY;
      m1_DAT_I = g1 ? s_DAT_I : '0;
      state_d  = state_q;
      case (state_q)
         IDLE:    state_d = (r0 & r1) ? (last_q ? GNT0 : GNT1) : r0 ? GNT0 : r1 ? GNT1 : IDLE;
         GNT0:    state_d = expire ? ABORT : m0_CYC ? GNT0 : r1 ? GNT1 : IDLE;
         GNT1:    state_d = expire ? ABORT : m1_CYC ? GNT1 : r0 ? GNT0 : IDLE;
         default: state_d = IDLE;
      endcase
      last_d   = (state_d == GNT0 && !g0) ? 1'b0 : (state_d == GNT1 && !g1) ? 1'b1 : last_q;
      wd_d     = (state_d != state_q) ? '0 : ((g0 | g1) & s_STB & ~term) ? wd_q + 1'b1 : '0;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         wd_q    <= wd_d;
      end
   end
endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// tb_sdram_wb_arbiter: vector table, directed corner sequences and randomized model check
module tb_sdram_wb_arbiter;
   localparam int TO = 16;
   logic        clk, rst;
   logic [1:0]  cyc, stb, we;
   logic [31:0] adr [2];
   logic [31:0] dat [2];
   logic [2:0]  cti [2];
   logic [31:0] m0_DAT_I, m1_DAT_I, s_DAT_I, s_DAT_O, s_ADR;
   logic        m0_ACK, m0_ERR, m0_RTY, m1_ACK, m1_ERR, m1_RTY;
   logic        s_CYC, s_STB, s_WE, s_ACK, s_ERR, s_RTY;
   logic [2:0]  s_CTI_O;
   logic [1:0]  gnt;
   int          checks, failures;
   int          owner, lastm, stall, m, nxt;
   bit          g, term, to;
   logic        quiet;

   typedef struct {
      logic [1:0] cyc, stb;
      logic [2:0] cti0;
      logic       ack;
      logic [1:0] gnt, acks;
      logic [2:0] scti;
   } vec_t;
   vec_t tbl [18];

   sdram_wb_arbiter #(.TIMEOUT(TO), .AW(32)) dut (
      .clk(clk), .rst(rst),
      .m0_CYC(cyc[0]), .m0_STB(stb[0]), .m0_WE(we[0]), .m0_ADR(adr[0]), .m0_DAT_O(dat[0]),
      .m0_CTI_O(cti[0]), .m0_DAT_I(m0_DAT_I), .m0_ACK(m0_ACK), .m0_ERR(m0_ERR), .m0_RTY(m0_RTY),
      .m1_CYC(cyc[1]), .m1_STB(stb[1]), .m1_WE(we[1]), .m1_ADR(adr[1]), .m1_DAT_O(dat[1]),
      .m1_CTI_O(cti[1]), .m1_DAT_I(m1_DAT_I), .m1_ACK(m1_ACK), .m1_ERR(m1_ERR), .m1_RTY(m1_RTY),
      .s_CYC(s_CYC), .s_STB(s_STB), .s_WE(s_WE), .s_ADR(s_ADR), .s_DAT_O(s_DAT_O),
      .s_CTI_O(s_CTI_O), .s_DAT_I(s_DAT_I), .s_ACK(s_ACK), .s_ERR(s_ERR), .s_RTY(s_RTY),
      .gnt(gnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b0; cyc = '0; stb = '0; we = '0;
      adr[0] = '0; adr[1] = '0; dat[0] = 32'h0A0A0A0A; dat[1] = 32'h1B1B1B1B;
      cti[0] = '0; cti[1] = '0;
      s_ACK = 0; s_ERR = 0; s_RTY = 0; s_DAT_I = 32'hDEADBEEF; quiet = 0;
      #3;
      chk("reset_gnt", gnt, 2'b00);
      chk("reset_scyc", {s_CYC, s_STB, s_WE}, 3'b000);
      @(negedge clk); rst = 1'b1;
      // tie, burst lock, handover, CYC-without-STB, round robin
      tbl[0]  = '{2'b11, 2'b11, 3'b000, 1'b0, 2'b00, 2'b00, 3'b000};
      tbl[1]  = '{2'b11, 2'b11, 3'b010, 1'b1, 2'b01, 2'b01, 3'b010};
      tbl[2]  = '{2'b11, 2'b11, 3'b010, 1'b1, 2'b01, 2'b01, 3'b010};
      tbl[3]  = '{2'b11, 2'b11, 3'b010, 1'b1, 2'b01, 2'b01, 3'b010};
      tbl[4]  = '{2'b11, 2'b11, 3'b111, 1'b1, 2'b01, 2'b01, 3'b111};
      tbl[5]  = '{2'b10, 2'b10, 3'b000, 1'b0, 2'b01, 2'b00, 3'b000};
      tbl[6]  = '{2'b10, 2'b10, 3'b000, 1'b1, 2'b10, 2'b10, 3'b000};
      tbl[7]  = '{2'b00, 2'b00, 3'b000, 1'b0, 2'b10, 2'b00, 3'b000};
      tbl[8]  = '{2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 3'b000};
      tbl[9]  = '{2'b01, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 3'b000};
      tbl[10] = '{2'b01, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 3'b000};
      tbl[11] = '{2'b01, 2'b01, 3'b000, 1'b0, 2'b00, 2'b00, 3'b000};
      tbl[12] = '{2'b01, 2'b01, 3'b000, 1'b1, 2'b01, 2'b01, 3'b000};
      tbl[13] = '{2'b00, 2'b00, 3'b000, 1'b0, 2'b01, 2'b00, 3'b000};
      tbl[14] = '{2'b11, 2'b11, 3'b000, 1'b0, 2'b00, 2'b00, 3'b000};
      tbl[15] = '{2'b11, 2'b11, 3'b000, 1'b1, 2'b10, 2'b10, 3'b000};
      tbl[16] = '{2'b00, 2'b00, 3'b000, 1'b0, 2'b10, 2'b00, 3'b000};
      tbl[17] = '{2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 3'b000};
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         cyc = tbl[i].cyc; stb = tbl[i].stb; cti[0] = tbl[i].cti0; s_ACK = tbl[i].ack;
         #1;
         chk($sformatf("vec%0d_gnt", i), gnt, tbl[i].gnt);
         chk($sformatf("vec%0d_acks", i), {m1_ACK, m0_ACK}, tbl[i].acks);
         chk($sformatf("vec%0d_cti", i), s_CTI_O, tbl[i].scti);
      end
      cti[0] = '0; s_ACK = 0;
      // timeout: ERR on the 16th stalled strobe, one ABORT cycle, IDLE, then regrant
      @(negedge clk); cyc[0] = 1; stb[0] = 1; #1;
      chk("to_idle", gnt, 2'b00);
      for (int k = 1; k <= TO; k++) begin
         @(negedge clk); #1;
         chk($sformatf("to_gnt%0d", k), gnt, 2'b01);
         chk($sformatf("to_err%0d", k), m0_ERR, k == TO);
      end
      @(negedge clk); #1;
      chk("to_abort_gnt", gnt, 2'b00);
      chk("to_abort_scyc", s_CYC, 1'b0);
      @(negedge clk); #1;
      chk("to_after_idle", gnt, 2'b00);
      @(negedge clk); #1;
      chk("to_regrant", gnt, 2'b01);
      chk("to_regrant_err", m0_ERR, 1'b0);
      for (int k = 2; k < TO; k++) begin
         @(negedge clk); #1;
         chk($sformatf("to2_err%0d", k), m0_ERR, 1'b0);
      end
      // termination arriving in the expiry cycle wins
      @(negedge clk); s_ACK = 1; #1;
      chk("late_ack_err", m0_ERR, 1'b0);
      chk("late_ack_ack", m0_ACK, 1'b1);
      @(negedge clk); s_ACK = 0; #1;
      chk("late_ack_noabort", gnt, 2'b01);
      cyc = '0; stb = '0;
      @(negedge clk);
      // single m1 read
      @(negedge clk); cyc[1] = 1; stb[1] = 1; we[1] = 0; adr[1] = 32'h100; #1;
      chk("rd_pre_gnt", gnt, 2'b00);
      chk("rd_pre_stb", s_STB, 1'b0);
      @(negedge clk); s_ACK = 1; s_DAT_I = 32'hDEADBEEF; #1;
      chk("rd_gnt", gnt, 2'b10);
      chk("rd_stb", s_STB, 1'b1);
      chk("rd_adr", s_ADR, 32'h100);
      chk("rd_m1", {m1_ACK, m1_DAT_I}, {1'b1, 32'hDEADBEEF});
      chk("rd_m0", {m0_ACK, m0_DAT_I}, 33'd0);
      @(negedge clk); s_ACK = 0; cyc = '0; stb = '0;
      @(negedge clk);
      // async reset mid-grant
      @(negedge clk); cyc[0] = 1; stb[0] = 1;
      @(negedge clk); s_ACK = 1; #1;
      chk("ar_pre_gnt", gnt, 2'b01);
      #2 rst = 1'b0; #1;
      chk("ar_gnt", gnt, 2'b00);
      chk("ar_scyc", s_CYC, 1'b0);
      chk("ar_ack", m0_ACK, 1'b0);
      @(negedge clk); s_ACK = 0; cyc = 2'b11; stb = 2'b11; rst = 1'b1; #1;
      chk("ar_rel_gnt", gnt, 2'b00);
      @(negedge clk); #1;
      chk("ar_tie_gnt", gnt, 2'b01);
      // randomized run against the reference model
      @(negedge clk); rst = 1'b0; cyc = '0; stb = '0;
      @(negedge clk); rst = 1'b1;
      owner = -1; lastm = 1; stall = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(7) == 0) cyc[i] = ~cyc[i];
            stb[i] = cyc[i] ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            we[i] = 1'($urandom); adr[i] = $urandom; dat[i] = $urandom; cti[i] = 3'($urandom);
         end
         if ($urandom_range(63) == 0) quiet = ~quiet;
         s_ACK = !quiet && $urandom_range(2) == 0;
         s_ERR = !quiet && $urandom_range(15) == 0;
         s_RTY = !quiet && $urandom_range(15) == 0;
         s_DAT_I = $urandom;
         #1;
         g = owner == 0 || owner == 1;
         m = g ? owner : 0;
         term = s_ACK | s_ERR | s_RTY;
         to = g && cyc[m] && stb[m] && !term && stall == TO - 1;
         chk("rnd_gnt", gnt, owner == 0 ? 2'b01 : owner == 1 ? 2'b10 : 2'b00);
         chk("rnd_bus", {s_CYC, s_STB, s_WE, s_ADR, s_DAT_O, s_CTI_O},
             g ? {cyc[m], stb[m], we[m], adr[m], dat[m], cti[m]} : 70'd0);
         chk("rnd_m0", {m0_ACK, m0_ERR, m0_RTY, m0_DAT_I},
             (g && m == 0) ? {s_ACK, s_ERR | to, s_RTY, s_DAT_I} : 35'd0);
         chk("rnd_m1", {m1_ACK, m1_ERR, m1_RTY, m1_DAT_I},
             (g && m == 1) ? {s_ACK, s_ERR | to, s_RTY, s_DAT_I} : 35'd0);
         if (owner == 2) nxt = -1;
         else if (!g) begin
            if (cyc[0] && stb[0] && cyc[1] && stb[1]) nxt = 1 - lastm;
            else nxt = (cyc[0] && stb[0]) ? 0 : (cyc[1] && stb[1]) ? 1 : -1;
         end else if (to) nxt = 2;
         else if (cyc[m]) nxt = m;
         else nxt = (cyc[1-m] && stb[1-m]) ? 1 - m : -1;
         if ((nxt == 0 || nxt == 1) && nxt != owner) lastm = nxt;
         stall = (nxt != owner) ? 0 : (g && stb[m] && !term) ? stall + 1 : 0;
         owner = nxt;
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sdram_wb_arbiter.md
SDRAM_WB_ARBITER -- requirements
Module: sdram_wb_arbiter

Interface
- REQ-001 Parameter TIMEOUT, default 1024: cycles a granted strobe may wait for ACK/ERR/RTY before abort.
- REQ-002 Parameter AW, default 32: address width. Data width is fixed at 32.
- REQ-003 clk  input  1  system clock; all state is updated on its rising edge.
- REQ-004 rst  input  1  reset, asynchronous and active-low (0 = reset).
- REQ-005 m0_CYC, m0_STB, m0_WE  input  1 each  master 0 (instruction fetch) Wishbone cycle, strobe and write enable.
- REQ-006 m0_ADR  input  AW  master 0 address.
- REQ-007 m0_DAT_O  input  32  master 0 write data.
- REQ-008 m0_CTI_O  input  3  master 0 cycle type.
- REQ-009 m0_DAT_I  output  32  master 0 read data.
- REQ-010 m0_ACK, m0_ERR, m0_RTY  output  1 each  master 0 termination signals.
- REQ-011 Master 1 (data port) has the identical set of ports, prefixed m1_.
- REQ-012 s_CYC, s_STB, s_WE  output  1 each  slave-side (SDRAM controller) cycle, strobe and write enable.
- REQ-013 s_ADR  output  AW  slave address.
- REQ-014 s_DAT_O  output  32  slave write data.
- REQ-015 s_CTI_O  output  3  slave cycle type.
- REQ-016 s_DAT_I  input  32  slave read data.
- REQ-017 s_ACK, s_ERR, s_RTY  input  1 each  slave terminations.
- REQ-018 gnt  output  2  one-hot current grant: bit0 = m0, bit1 = m1, 00 = none.

Function
- REQ-019 The FSM SHALL have the states IDLE, GNT0, GNT1 and ABORT; grant and state are registered.
- REQ-020 Request definition: a master requests when its CYC and STB are both 1.
- REQ-021 IDLE, one request pending: go to that master's GNTx next cycle (grant latency = 1 cycle).
- REQ-022 IDLE, both requesting: grant the master not in last_grant (round-robin); last_grant updates on every grant.
- REQ-023 GNTx: hold the grant while mx_CYC=1, so bursts (CTI_O=010) are never split.
- REQ-024 GNTx, mx_CYC falls: if the other master requests in that same cycle, go directly to GNTy; otherwise go to IDLE.
- REQ-025 Granted: s_CYC/s_STB/s_WE/s_ADR/s_DAT_O/s_CTI_O are combinationally driven from the granted master.
- REQ-026 Granted: s_ACK/s_ERR/s_RTY/s_DAT_I are routed to the granted master only.
- REQ-027 The non-granted master sees ACK=ERR=RTY=0 and DAT_I=0.
- REQ-028 With no grant (IDLE, ABORT): s_CYC=s_STB=s_WE=0, s_ADR=0, s_DAT_O=0, s_CTI_O=000.
- REQ-029 Watchdog counter (clog2(TIMEOUT) bits): increments each cycle in GNTx with s_STB=1 and no s_ACK/s_ERR/s_RTY; clears otherwise and on every grant change.
- REQ-030 Watchdog expiry (counter = TIMEOUT-1 without termination):
  - assert mx_ERR=1 for exactly that cycle, regardless of slave outputs;
  - enter ABORT.
- REQ-031 ABORT lasts exactly 1 cycle with s_CYC=0, then IDLE; a master still holding CYC is re-arbitrated normally.
- REQ-032 A slave termination arriving in the expiry cycle takes precedence: it is forwarded, no ERR is forced, no abort.
- REQ-033 The arbiter never grants on CYC=1 with STB=0 from IDLE, and never preempts a granted master.

Reset
- REQ-034 rst=0 SHALL immediately (asynchronously) force:
  - state=IDLE, gnt=00, watchdog=0;
  - last_grant=m1, so m0 wins the first tie;
  - all slave-side and master termination outputs to 0.
- REQ-035 Reset asserted mid-burst SHALL drop s_CYC in the same cycle; after release, arbitration restarts from IDLE.

Verification
- REQ-036 Single master: m1 read request at cycle n -> gnt=10 and s_STB=1 at n+1; s_ACK with s_DAT_I=0xDEADBEEF appears on m1_DAT_I/m1_ACK; m0_ACK=0.
- REQ-037 Tie after reset: m0 and m1 request together -> gnt=01 first; on m0 CYC drop with m1 still requesting, gnt=10 the same next cycle with no IDLE.
- REQ-038 Burst lock: m0 4-beat incrementing burst (CTI 010,010,010,111) while m1 requests -> gnt stays 01 for all 4 ACKs; m1 granted only after m0_CYC=0.
- REQ-039 Timeout: TIMEOUT=16, slave never answers -> m0_ERR=1 on the 16th strobe cycle; then s_CYC=0 for one cycle; then IDLE.
- REQ-040 Async reset: rst=0 mid-grant between clock edges -> gnt=00 and s_CYC=0 before the next edge; after release, m0 wins the first tie.
